// File: rtl/nonce_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nonce_dispatcher_pkg
// Brief    : Shared widths, state encoding and byte-swap helper for the
//            nonce dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package nonce_dispatcher_pkg;

    localparam int HEADER_W   = 640;
    localparam int TEMPLATE_W = 608;
    localparam int DIGEST_W   = 256;
    localparam int NONCE_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // The header carries the nonce little-endian.
    function automatic logic [NONCE_W-1:0] byteswap32(input logic [NONCE_W-1:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : nonce_dispatcher_if
// Brief    : Request/response bus between the dispatcher and a hasher.
// Revision : 1.0 - initial release
// ============================================================================
interface nonce_dispatcher_if;
    import nonce_dispatcher_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [HEADER_W-1:0]   req_header;
    logic [NONCE_W-1:0]    req_nonce;
    logic                  rsp_valid;
    logic [NONCE_W-1:0]    rsp_nonce;
    logic [DIGEST_W-1:0]   rsp_digest;

    modport master (
        output req_valid, req_header, req_nonce,
        input  req_ready, rsp_valid, rsp_nonce, rsp_digest
    );

    modport slave (
        input  req_valid, req_header, req_nonce,
        output req_ready, rsp_valid, rsp_nonce, rsp_digest
    );

endinterface
`default_nettype wire

// File: rtl/nonce_dispatcher_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : nonce_dispatcher_credit_counter
// Brief    : Outstanding-request counter with full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_dispatcher_credit_counter #(
    parameter int CREDITS = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic inc,
    input  wire logic dec,
    output logic      full,
    output logic      empty
);

    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0] r_count;
    logic          w_dec;

    // A response with nothing outstanding is stale and must not underflow.
    assign w_dec = dec && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && !w_dec) begin
            r_count <= r_count + CW'(1);
        end else if (!inc && w_dec) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign full  = (r_count >= CW'(CREDITS));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/nonce_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : nonce_dispatcher
// Brief    : Sweeps the nonce over a latched header template, feeds headers
//            to the hasher and reports the first digest <= target.
//            Optional macro NONCE_RANGE_EN adds nonce_first/nonce_last ports.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_dispatcher
    import nonce_dispatcher_pkg::*;
#(
    parameter int CREDITS = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    input  wire logic                  abort,
    input  wire logic [TEMPLATE_W-1:0] template,
    input  wire logic [DIGEST_W-1:0]   target,
`ifdef NONCE_RANGE_EN
    input  wire logic [NONCE_W-1:0]    nonce_first,
    input  wire logic [NONCE_W-1:0]    nonce_last,
`endif
    output logic                       busy,
    nonce_dispatcher_if.master         hasher,
    output logic                       found,
    output logic [NONCE_W-1:0]         found_nonce,
    output logic [DIGEST_W-1:0]        found_digest,
    output logic                       done
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TEMPLATE_W-1:0] r_template;
    logic [DIGEST_W-1:0]   r_target;
    logic [NONCE_W-1:0]    r_nonce;
    logic [NONCE_W-1:0]    r_last;
    logic                  r_last_issued;
    logic                  r_matched;
    logic                  r_hold;
    logic                  r_found;
    logic [NONCE_W-1:0]    r_found_nonce;
    logic [DIGEST_W-1:0]   r_found_digest;

    logic [NONCE_W-1:0]    w_first;
    logic [NONCE_W-1:0]    w_last;
    logic                  w_start_acc;
    logic                  w_req_valid;
    logic                  w_fire;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rsp_take;
    logic                  w_match;

`ifdef NONCE_RANGE_EN
    assign w_first = nonce_first;
    assign w_last  = nonce_last;
`else
    assign w_first = 32'h0000_0000;
    assign w_last  = 32'hFFFF_FFFF;
`endif

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_fire      = w_req_valid && hasher.req_ready;
    assign w_rsp_take  = hasher.rsp_valid && !w_empty &&
                         ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_match     = w_rsp_take && !r_matched && (hasher.rsp_digest <= r_target);

    nonce_dispatcher_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start_acc),
        .inc   (w_fire),
        .dec   (w_rsp_take),
        .full  (w_full),
        .empty (w_empty)
    );

    // r_hold keeps an offered request up until it is accepted, so abort or a
    // match never withdraws req_valid mid-handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_req_valid = r_hold ||
                              (!w_full && !r_last_issued && !abort && !r_matched && !w_match);
                if (r_last_issued && w_empty) begin
                    w_state_nxt = ST_REPORT;
                end else if ((abort || r_matched || w_match) &&
                             !(w_req_valid && !hasher.req_ready)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_template     <= '0;
            r_target       <= '0;
            r_nonce        <= '0;
            r_last         <= '0;
            r_last_issued  <= 1'b0;
            r_matched      <= 1'b0;
            r_hold         <= 1'b0;
            r_found        <= 1'b0;
            r_found_nonce  <= '0;
            r_found_digest <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_found <= w_match;
            r_hold  <= w_req_valid && !hasher.req_ready;

            if (w_start_acc) begin
                r_template     <= template;
                r_target       <= target;
                r_nonce        <= w_first;
                r_last         <= w_last;
                // An empty range behaves as already exhausted.
                r_last_issued  <= (w_first > w_last);
                r_matched      <= 1'b0;
                r_found_nonce  <= '0;
                r_found_digest <= '0;
            end else if (w_fire) begin
                if (r_nonce == r_last) begin
                    r_last_issued <= 1'b1;
                end else begin
                    r_nonce <= r_nonce + 32'd1;
                end
            end

            if (w_match) begin
                r_matched      <= 1'b1;
                r_found_nonce  <= hasher.rsp_nonce;
                r_found_digest <= hasher.rsp_digest;
            end
        end
    end

    assign hasher.req_valid  = w_req_valid;
    assign hasher.req_nonce  = r_nonce;
    assign hasher.req_header = {r_template, byteswap32(r_nonce)};

    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_REPORT);
    assign found        = r_found;
    assign found_nonce  = r_found_nonce;
    assign found_digest = r_found_digest;

endmodule
`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_dispatcher
// Brief    : Directed bench with a fixed-latency mock hasher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_dispatcher;
    import nonce_dispatcher_pkg::*;

    localparam int CREDITS = 2;
    localparam int LAT     = 3;

    typedef struct {
        logic [31:0] n;
        int          due;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [TEMPLATE_W-1:0] tmpl = {19{32'hA5C3_0F1E}};
    logic [DIGEST_W-1:0]   tgt = '0;
    logic [31:0]           nfirst = 32'h0;
    logic [31:0]           nlast  = 32'hFFFF_FFFF;
    logic                  busy, found, done;
    logic [31:0]           found_nonce;
    logic [DIGEST_W-1:0]   found_digest;

    nonce_dispatcher_if hif();

    nonce_dispatcher #(.CREDITS(CREDITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .template     (tmpl),
        .target       (tgt),
`ifdef NONCE_RANGE_EN
        .nonce_first  (nfirst),
        .nonce_last   (nlast),
`endif
        .busy         (busy),
        .hasher       (hif),
        .found        (found),
        .found_nonce  (found_nonce),
        .found_digest (found_digest),
        .done         (done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rsp_sent = 0;
    int          hdr_err = 0;
    int          rsp5_at = -1;
    bit          mock_en = 1'b1;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_nonce = '0;
    logic [255:0] inj_digest = '0;
    logic [31:0] fire_log[$];
    ent_t        mq[$];
    int          found_cnt, found_at, done_at;

    function automatic logic [31:0] tb_swap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [255:0] mock_digest(input logic [31:0] n);
        return (n == 32'd5) ? 256'd0 : {256{1'b1}};
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mock hasher: responds LAT cycles after each accepted request.
    always @(posedge clk) begin
        #2;
        if (rst) mq.delete();
        hif.rsp_valid  = 1'b0;
        hif.rsp_nonce  = '0;
        hif.rsp_digest = '0;
        if (inj_valid) begin
            hif.rsp_valid  = 1'b1;
            hif.rsp_nonce  = inj_nonce;
            hif.rsp_digest = inj_digest;
        end else if (mock_en && mq.size() > 0 && mq[0].due <= cyc) begin
            hif.rsp_valid  = 1'b1;
            hif.rsp_nonce  = mq[0].n;
            hif.rsp_digest = mock_digest(mq[0].n);
            if (mq[0].n == 32'd5) rsp5_at = cyc;
            void'(mq.pop_front());
            rsp_sent++;
        end
    end

    always @(negedge clk) begin
        if (!rst && hif.req_valid && hif.req_ready) begin
            mq.push_back('{n: hif.req_nonce, due: cyc + LAT});
            fire_log.push_back(hif.req_nonce);
            if (hif.req_header[31:0] !== tb_swap(hif.req_nonce) ||
                hif.req_header[639:32] !== tmpl)
                hdr_err++;
        end
    end

    task automatic do_start(input logic [255:0] t);
        @(posedge clk); #1;
        tgt   = t;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        found_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (found) begin found_cnt++; found_at = cyc; end
            if (done) begin ok = 1'b1; done_at = cyc; break; end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          base, rbase;
        logic [31:0] mx;
        logic [639:0] hdr0;
        bit          quiet;

        hif.req_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_req_valid", hif.req_valid, 0);
        check_eq("rst_found", found, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_header", hif.req_header, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Match at nonce 5 with target 0
        base = fire_log.size();
        do_start(256'd0);
        @(negedge clk);
        check_eq("t1_busy_n1", busy, 1);
        check_eq("t1_valid_n1", hif.req_valid, 1);
        wait_done(200, ok);
        check_eq("t1_done", ok, 1);
        check_eq("t1_found_cnt", found_cnt, 1);
        check_eq("t1_found_nonce", found_nonce, 32'd5);
        check_eq("t1_found_digest", found_digest, 256'd0);
        check_eq("t1_found_latency", found_at, rsp5_at + 1);
        check_eq("t1_done_after_found", (done_at >= found_at + 1), 1);
        @(negedge clk);
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_nonce_held", found_nonce, 32'd5);

        // Target all-ones: nonce 0 matches, nothing past CREDITS-1 issued
        base = fire_log.size();
        do_start({256{1'b1}});
        wait_done(200, ok);
        check_eq("t2_done", ok, 1);
        check_eq("t2_found_nonce", found_nonce, 32'd0);
        check_eq("t2_found_digest", found_digest, {256{1'b1}});
        mx = 0;
        for (int i = base; i < fire_log.size(); i++)
            if (fire_log[i] > mx) mx = fire_log[i];
        check_eq("t2_max_nonce", mx, CREDITS - 1);

        // Backpressure: request stable while not accepted
        @(posedge clk); #1;
        hif.req_ready = 1'b0;
        do_start(256'd0);
        @(negedge clk);
        check_eq("t3_valid", hif.req_valid, 1);
        check_eq("t3_nonce0", hif.req_nonce, 32'd0);
        hdr0 = hif.req_header;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_hdr_stable", hif.req_header, hdr0);
        end
        check_eq("t3_nonce_hold", hif.req_nonce, 32'd0);
        @(posedge clk); #1;
        hif.req_ready = 1'b1;
        @(posedge clk); #1;
        hif.req_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_nonce1", hif.req_nonce, 32'd1);
        check_eq("t3_hdr_swap", hif.req_header[31:0], 32'h0100_0000);
        check_eq("t3_hdr_tmpl", hif.req_header[639:32], tmpl);
        @(posedge clk); #1;
        hif.req_ready = 1'b1;
        wait_done(200, ok);
        check_eq("t3_done", ok, 1);
        check_eq("t3_found_nonce", found_nonce, 32'd5);

        // Abort with two requests in flight
        base  = fire_log.size();
        rbase = rsp_sent;
        do_start(256'd0);
        for (int i = 0; i < 20 && fire_log.size() - base < 2; i++) @(negedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check_eq("t4_valid_off", hif.req_valid, 0);
        wait_done(50, ok);
        check_eq("t4_done", ok, 1);
        check_eq("t4_found_cnt", found_cnt, 0);
        check_eq("t4_fires", fire_log.size() - base, 2);
        check_eq("t4_rsps", rsp_sent - rbase, 2);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_eq("t4_busy_after", busy, 0);

`ifdef NONCE_RANGE_EN
        // Top-of-range sweep must not wrap
        nfirst = 32'hFFFF_FFFE;
        nlast  = 32'hFFFF_FFFF;
        base   = fire_log.size();
        do_start(256'd0);
        wait_done(100, ok);
        check_eq("t5_done", ok, 1);
        check_eq("t5_found_cnt", found_cnt, 0);
        check_eq("t5_fires", fire_log.size() - base, 2);
        check_eq("t5_last_nonce", fire_log[fire_log.size() - 1], 32'hFFFF_FFFF);
        // Empty range: done at N+2, nothing issued
        nfirst = 32'd10;
        nlast  = 32'd5;
        base   = fire_log.size();
        do_start(256'd0);
        @(negedge clk);
        check_eq("t5_empty_n1", done, 0);
        @(negedge clk);
        check_eq("t5_empty_n2", done, 1);
        check_eq("t5_empty_fires", fire_log.size() - base, 0);
        nfirst = 32'h0;
        nlast  = 32'hFFFF_FFFF;
        @(negedge clk);
`endif

        // Reset mid-sweep, then a stale response
        do_start(256'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        inj_valid  = 1'b1;
        inj_nonce  = 32'd5;
        inj_digest = 256'd0;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (found || done || busy || hif.req_valid) quiet = 1'b0;
        end
        check_eq("t6_quiet", quiet, 1);
        check_eq("t6_found_nonce_clr", found_nonce, 0);
        do_start(256'd0);
        @(negedge clk);
        check_eq("t6_restart_nonce", hif.req_nonce, 32'd0);
        wait_done(200, ok);
        check_eq("t6_done", ok, 1);
        check_eq("t6_found_nonce", found_nonce, 32'd5);

        check_eq("hdr_errors", hdr_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
